// File: rtl/irq_ctrl_if.sv
// Bridge-side register bus for the interrupt controller (DEV2 slot).
//   DEV_Addr : word select (bridge address bits [3:2])
//   DEV_WD   : write data
//   DEV_WE   : write strobe, already qualified by the address decode
//   DEV_RD   : read data, combinational from the selected register
interface irq_ctrl_if;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic        DEV_WE;
  logic [31:0] DEV_RD;

  modport master (output DEV_Addr, DEV_WD, DEV_WE, input DEV_RD);
  modport slave  (input DEV_Addr, DEV_WD, DEV_WE, output DEV_RD);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller. Samples up to six interrupt lines,
// applies per-source mask and edge/level mode, and presents one prioritised
// one-hot request to CP0. Tracks ack/ERET so only one source is in service.
//   clk, reset : clock, synchronous active-high reset
//   bus        : register bus (0 CTRL, 1 PEND W1C, 2 STAT, 3 reserved)
//   irq_src    : raw interrupt lines, index 0 = highest priority
//   int_ack    : CP0 took a hardware-interrupt exception (one-cycle pulse)
//   eret       : ERET retired (one-cycle pulse)
//   HWInt      : registered one-hot request, bits >= NSRC always 0
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] irq_src,
  input  logic            int_ack,
  input  logic            eret,
  output logic [5:0]      HWInt
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  // Implemented-source mask; CTRL bits for absent sources read back 0.
  localparam logic [5:0] VALID = 6'((7'd1 << NSRC) - 7'd1);

  state_t     state;
  logic [5:0] src_pad, src_q, src_q_d, pend;
  logic [5:0] mask, mode;
  logic       ge;
  logic [2:0] cur_id;
  logic [5:0] eff, onehot, w1c, ack_clr;
  logic [31:0] rd;

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_pad
      if (g < NSRC) begin : g_src
        assign src_pad[g] = irq_src[g];
      end else begin : g_zero
        assign src_pad[g] = 1'b0;
      end
    end
  endgenerate

  function automatic logic [2:0] enc(input logic [5:0] oh);
    enc = 3'd0;
    for (int i = 0; i < 6; i++)
      if (oh[i]) enc = 3'(i);
  endfunction

  always_comb begin
    eff     = pend & mask & {6{ge}};
    onehot  = eff & (~eff + 6'd1);  // isolate lowest set bit = highest priority
    w1c     = (bus.DEV_WE && bus.DEV_Addr == 2'd1) ? bus.DEV_WD[5:0] : 6'd0;
    // Clear the source CP0 actually saw, i.e. the registered request.
    ack_clr = (state == REQ && int_ack) ? HWInt : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      src_q_d <= '0;
      pend    <= '0;
      mask    <= '0;
      mode    <= '0;
      ge      <= 1'b0;
      state   <= IDLE;
      cur_id  <= '0;
      HWInt   <= '0;
    end else begin
      src_q   <= src_pad;
      src_q_d <= src_q;

      if (bus.DEV_WE && bus.DEV_Addr == 2'd0) begin
        mask <= bus.DEV_WD[5:0] & VALID;
        mode <= bus.DEV_WD[13:8] & VALID;
        ge   <= bus.DEV_WD[31];
      end

      // Edge bits latch with set-over-clear; level bits just follow src_q.
      for (int i = 0; i < 6; i++) begin
        if (mode[i]) begin
          if (src_q[i] & ~src_q_d[i])    pend[i] <= 1'b1;
          else if (w1c[i] | ack_clr[i])  pend[i] <= 1'b0;
        end else begin
          pend[i] <= src_q[i];
        end
      end

      case (state)
        IDLE: begin
          if (eff != 6'd0) begin
            state <= REQ;
            HWInt <= onehot;
          end
        end
        REQ: begin
          if (int_ack) begin
            state  <= SERVICE;
            cur_id <= enc(HWInt);
            HWInt  <= '0;
          end else if (eff == 6'd0) begin
            state <= IDLE;
            HWInt <= '0;
          end else begin
            HWInt <= onehot;
          end
        end
        SERVICE: begin
          HWInt <= '0;
          if (eret) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          HWInt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (bus.DEV_Addr)
      2'd0: begin
        rd[31]   = ge;
        rd[13:8] = mode;
        rd[5:0]  = mask;
      end
      2'd1: rd[5:0] = pend;
      2'd2: begin
        rd[31]    = (state == SERVICE);
        rd[18:16] = cur_id;
        rd[9:8]   = state;
        rd[5:0]   = eff;
      end
      default: rd = '0;
    endcase
  end

  assign bus.DEV_RD = rd;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] irq_src;
  logic       int_ack, eret;
  logic [5:0] HWInt;
  int checks = 0;
  int errors = 0;

  irq_ctrl_if bus();

  irq_ctrl #(.NSRC(6)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq_src(irq_src),
    .int_ack(int_ack), .eret(eret), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus.DEV_Addr = a;
    #1;
    v = bus.DEV_RD;
    chk(tag, v, exp);
  endtask

  task automatic chk_hw(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, HWInt}, {26'd0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.DEV_Addr = a;
    bus.DEV_WD   = d;
    bus.DEV_WE   = 1'b1;
    tick(1);
    bus.DEV_WE   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; int_ack = 1'b0; eret = 1'b0;
    bus.DEV_Addr = '0; bus.DEV_WD = '0; bus.DEV_WE = 1'b0;
    tick(2);
    chk_hw("rst_hwint", 6'h00);
    chk_reg("rst_ctrl", 2'd0, 32'h0);
    chk_reg("rst_pend", 2'd1, 32'h0);
    chk_reg("rst_stat", 2'd2, 32'h0);
    reset = 1'b0;

    // 1: level request, ack, eret re-request
    wr(2'd0, 32'h8000_0003);
    irq_src = 6'b000010;
    tick(2);
    chk_hw("t1_lat_early", 6'h00);
    tick(1);
    chk_hw("t1_req", 6'h02);
    chk_reg("t1_stat_req", 2'd2, 32'h0000_0102);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    chk_hw("t1_ack_hw", 6'h00);
    chk_reg("t1_stat_svc", 2'd2, 32'h8001_0202);
    tick(2);
    chk_hw("t1_svc_hold", 6'h00);
    eret = 1'b1; tick(1); eret = 1'b0;
    chk_hw("t1_eret_1", 6'h00);
    tick(1);
    chk_hw("t1_eret_2", 6'h02);
    irq_src = 6'b0;
    tick(3);
    chk_hw("t1_drop", 6'h00);
    chk_reg("t1_stat_idle", 2'd2, 32'h0001_0000);

    // 2: priority replacement, all edge
    wr(2'd0, 32'h8000_3F3F);
    chk_reg("t2_ctrl", 2'd0, 32'h8000_3F3F);
    irq_src = 6'b100000; tick(1); irq_src = 6'b0;
    tick(2);
    chk_hw("t2_src5", 6'h20);
    irq_src = 6'b000010; tick(1); irq_src = 6'b0;
    tick(1);
    chk_hw("t2_still5", 6'h20);
    tick(1);
    chk_hw("t2_src1", 6'h02);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    chk_reg("t2_pend", 2'd1, 32'h0000_0020);
    chk_reg("t2_stat", 2'd2, 32'h8001_0220);
    wr(2'd1, 32'h0000_0020);
    chk_reg("t2_w1c", 2'd1, 32'h0);
    eret = 1'b1; tick(1); eret = 1'b0;
    tick(1);
    chk_hw("t2_idle", 6'h00);

    // 3: W1C racing a new rising edge
    irq_src = 6'b000100; tick(1); irq_src = 6'b0;
    tick(1);
    chk_reg("t3_pend_set", 2'd1, 32'h0000_0004);
    irq_src = 6'b000100; tick(1); irq_src = 6'b0;
    wr(2'd1, 32'h0000_0004);
    chk_reg("t3_race", 2'd1, 32'h0000_0004);
    wr(2'd1, 32'h0000_0004);
    chk_reg("t3_w1c", 2'd1, 32'h0);
    tick(1);
    chk_hw("t3_idle", 6'h00);
    chk_reg("t3_stat", 2'd2, 32'h0001_0000);

    // 4: masking while in REQ, then stray ack
    irq_src = 6'b001000;
    wr(2'd0, 32'h8000_0008);
    tick(2);
    chk_hw("t4_req", 6'h08);
    wr(2'd0, 32'h8000_0000);
    tick(1);
    chk_hw("t4_masked", 6'h00);
    chk_reg("t4_stat", 2'd2, 32'h0001_0000);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    chk_hw("t4_ack_ign", 6'h00);
    chk_reg("t4_stat_ack", 2'd2, 32'h0001_0000);

    // 5: GE=0, reserved address, STAT read-only
    irq_src = 6'b111111;
    wr(2'd0, 32'h0000_003F);
    tick(3);
    chk_hw("t5_ge0", 6'h00);
    chk_reg("t5_pend", 2'd1, 32'h0000_003F);
    chk_reg("t5_addr3", 2'd3, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    chk_reg("t5_stat_ro", 2'd2, 32'h0001_0000);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_reg("t5_ctrl_keep", 2'd0, 32'h0000_003F);
    wr(2'd0, 32'h8000_003F);
    tick(1);
    chk_hw("t5_ge1", 6'h01);

    // 6: reset during SERVICE with pending edges
    irq_src = 6'b0;
    tick(4);
    chk_hw("t6_settle", 6'h00);
    wr(2'd0, 32'h8000_3F3F);
    irq_src = 6'b000001; tick(1); irq_src = 6'b0;
    tick(2);
    chk_hw("t6_req", 6'h01);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    irq_src = 6'b100001; tick(1); irq_src = 6'b0;
    tick(1);
    chk_reg("t6_pend", 2'd1, 32'h0000_0021);
    chk_reg("t6_stat", 2'd2, 32'h8000_0221);
    reset = 1'b1; tick(1);
    chk_hw("t6_rst_hw", 6'h00);
    chk_reg("t6_rst_stat", 2'd2, 32'h0);
    chk_reg("t6_rst_pend", 2'd1, 32'h0);
    chk_reg("t6_rst_ctrl", 2'd0, 32'h0);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller on the device side of the bridge, as DEV2 (word offsets 0x0/0x4/0x8).
- Collects up to six hardware interrupt sources (Timer0, Timer1, external) and applies per-source mask and edge/level mode.
- Presents one prioritised request on HWInt to CP0 and tracks acknowledge/ERET so only one source is in service at a time (no nesting).

Parameters:
NSRC, 6, number of interrupt sources; maps onto Cause.IP[7:2]. Legal range 1..6.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
DEV_Addr  input  2  [3:2] register select from bridge
DEV_WD  input  32  write data from bridge
DEV_WE  input  1  write enable from bridge (already qualified by address hit)
DEV_RD  output  32  read data to bridge (combinational from registers)
irq_src  input  NSRC  raw interrupt lines; index 0 = highest priority
int_ack  input  1  one-cycle pulse from CP0 on exception entry for a hardware interrupt
eret  input  1  one-cycle pulse when ERET retires
HWInt  output  6  registered one-hot request to CP0; bits above NSRC-1 tied 0

Behaviour:
- Clocking: single clock domain. All state updates on posedge clk; reset is synchronous, active-high.
- Reset: CTRL=0, pend=0, src_q=0, state=IDLE, cur_id=0, HWInt=0.
- Registers:
  - Addr 0 CTRL (RW): [5:0] mask (1=enabled), [13:8] mode (1=edge, 0=level), [31] global enable (GE). Other bits read 0.
  - Addr 1 PEND (R/W1C): read returns pend[5:0]. Writing 1 clears edge-mode bits only; writes to level-mode bits are ignored.
  - Addr 2 STAT (RO): [31] in_service, [18:16] cur_id, [9:8] state (IDLE=0, REQ=1, SERVICE=2), [5:0] eff (effective pending). Writes ignored.
  - Addr 3: reads 0; writes ignored.
- Source sampling: src_q <= irq_src every cycle (one register stage).
  - Edge source: pend[i] sets on src_q[i] & ~src_q_d[i], where src_q_d is a second register stage. Set has priority over a same-cycle W1C or ack-clear.
  - Level source: pend[i] = src_q[i] each cycle; it is never latched.
- Effective pending: eff = pend & mask & {6{GE}}. sel = index of the lowest set bit of eff.
- FSM:
  - IDLE:
    - eff != 0 -> REQ; HWInt <= onehot(sel) on the same edge.
    - int_ack and eret are ignored.
  - REQ:
    - HWInt <= onehot(sel) each cycle, so a higher-priority arrival replaces the current request.
    - eff == 0 (masked, cleared, or level dropped) -> IDLE, HWInt <= 0.
    - int_ack -> SERVICE. cur_id <= index of the registered HWInt bit (the value CP0 saw, not the new sel). Clear pend[cur_id] if it is edge-mode. HWInt <= 0.
    - int_ack and eff == 0 in the same cycle: ack wins; cur_id comes from HWInt.
  - SERVICE:
    - HWInt held 0. New events still accumulate in pend.
    - eret -> IDLE; a re-request can appear no earlier than one cycle later.
    - int_ack is ignored.
- Latency:
  - irq_src edge to HWInt asserted: 3 cycles (src_q, pend, HWInt).
  - eret to HWInt re-asserted: 2 cycles.
- CTRL writes take effect on eff in the cycle after the write edge.
- Mode change of a bit from edge to level: its latched pend is overwritten by src_q next cycle.
- DEV_RD is a pure mux of register state; no read side effects.
- Reset mid-REQ or mid-SERVICE returns to IDLE with every edge pending lost.

Test Plan:
1. Reset, then CTRL=0x8000_0003 (GE, mask src0/1, level). Hold irq_src=6'b000010 -> HWInt=6'b000010 three cycles later, STAT[9:8]=1. Pulse int_ack -> HWInt=0, STAT=0x8001_0202. Pulse eret -> HWInt=6'b000010 again two cycles later (level still high).
2. Priority: CTRL=0x8000_3F3F (all edge). Pulse src5; while in REQ, pulse src1 -> HWInt changes 0x20 -> 0x02. int_ack -> cur_id=1, PEND reads 0x20 (src5 still pending).
3. W1C race: edge src2 pending, write PEND=0x04 in the same cycle as a new src2 rising edge -> PEND bit2 remains 1.
4. Masking in REQ: src3 level pending, HWInt=0x08; write CTRL mask bit3=0 -> state IDLE and HWInt=0 the next cycle; int_ack afterwards is ignored.
5. GE=0 with all sources pending -> HWInt stays 0. Reads of addr 3 return 0. A write of 0xFFFF_FFFF to STAT leaves it unchanged.
6. Assert reset during SERVICE with PEND=0x21 -> next cycle STAT=0, PEND=0, CTRL=0, HWInt=0.
